// File: rtl/instr_sequencer_if.sv
// Purpose : bundles the instruction-fetch and data-memory handshakes of the sequencer.
// Latency : pure wiring, no state.
// Backpressure: requests are held by the master until the slave returns the matching ack.
// Ports   : imem_req/imem_addr/imem_rdata/imem_ack fetch channel; dmem_req/dmem_we/dmem_ack data channel.
interface instr_sequencer_if #(
   parameter int PC_W = 8
);
   logic            imem_req;
   logic [PC_W-1:0] imem_addr;
   logic            imem_ack;
   logic [15:0]     imem_rdata;
   logic            dmem_req;
   logic            dmem_we;
   logic            dmem_ack;

   // Sequencer side
   modport master (
      output imem_req, imem_addr, dmem_req, dmem_we,
      input  imem_ack, imem_rdata, dmem_ack
   );

   // Memory side
   modport slave (
      input  imem_req, imem_addr, dmem_req, dmem_we,
      output imem_ack, imem_rdata, dmem_ack
   );
endinterface

// File: rtl/instr_sequencer.sv
// Purpose : multi-cycle control sequencer (fetch/decode/exec/mem/writeback) for a 16-bit ISA.
// Latency : ALU 4, LOAD 4, STORE 3, NOP/illegal/HALT 2 cycles with same-cycle acks.
// Backpressure: FETCH and MEM stall with their request held until the matching ack arrives.
// Ports   : clk, rst (sync, active-high), start; bus = fetch/data handshakes (master side);
//           ir = latched instruction, rf_we = writeback strobe, busy/halted status,
//           illegal_op = unassigned-opcode pulse, instr_count = saturating retire count.
module instr_sequencer #(
   parameter int PC_W = 8
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   instr_sequencer_if.master   bus,
   output logic [15:0]         ir,
   output logic                rf_we,
   output logic                busy,
   output logic                halted,
   output logic                illegal_op,
   output logic [15:0]         instr_count
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_DECODE,
      S_EXEC,
      S_MEM,
      S_WB,
      S_HALTED
   } state_t;

   state_t          state_q, state_d;
   logic [PC_W-1:0] pc_q, pc_d;
   logic [15:0]     ir_q, ir_d;
   logic [15:0]     cnt_q, cnt_d;
   logic            store_q, store_d;   // remembers LOAD vs STORE across the MEM wait
   logic            retire;
   logic [3:0]      opcode;

   assign opcode = ir_q[15:12];

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         pc_q    <= '0;
         ir_q    <= '0;
         cnt_q   <= '0;
         store_q <= 1'b0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         ir_q    <= ir_d;
         cnt_q   <= cnt_d;
         store_q <= store_d;
      end
   end

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      ir_d    = ir_q;
      cnt_d   = cnt_q;
      store_d = store_q;
      retire  = 1'b0;

      case (state_q)
         S_IDLE, S_HALTED: begin
            if (start) begin
               pc_d    = '0;
               cnt_d   = '0;
               state_d = S_FETCH;
            end
         end
         S_FETCH: begin
            if (bus.imem_ack) begin
               ir_d    = bus.imem_rdata;
               pc_d    = pc_q + PC_W'(1);   // wraps naturally at 2^PC_W
               state_d = S_DECODE;
            end
         end
         S_DECODE: begin
            case (opcode)
               4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6: state_d = S_EXEC;
               4'h7: begin
                  store_d = 1'b0;
                  state_d = S_MEM;
               end
               4'h8: begin
                  store_d = 1'b1;
                  state_d = S_MEM;
               end
               4'hF: begin
                  retire  = 1'b1;
                  state_d = S_HALTED;
               end
               // NOP and unassigned opcodes both retire straight back to fetch
               default: begin
                  retire  = 1'b1;
                  state_d = S_FETCH;
               end
            endcase
         end
         S_EXEC: state_d = S_WB;
         S_MEM: begin
            if (bus.dmem_ack) begin
               if (store_q) begin
                  retire  = 1'b1;
                  state_d = S_FETCH;
               end else begin
                  state_d = S_WB;
               end
            end
         end
         S_WB: begin
            retire  = 1'b1;
            state_d = S_FETCH;
         end
         default: state_d = S_IDLE;
      endcase

      if (retire && (cnt_q != 16'hFFFF)) begin
         cnt_d = cnt_q + 16'd1;
      end
   end

   // All outputs decode from registered state only
   assign bus.imem_req  = (state_q == S_FETCH);
   assign bus.imem_addr = pc_q;
   assign bus.dmem_req  = (state_q == S_MEM);
   assign bus.dmem_we   = (state_q == S_MEM) && store_q;
   assign rf_we         = (state_q == S_WB);
   assign busy          = (state_q != S_IDLE) && (state_q != S_HALTED);
   assign halted        = (state_q == S_HALTED);
   assign illegal_op    = (state_q == S_DECODE) && (opcode >= 4'h9) && (opcode <= 4'hE);
   assign ir            = ir_q;
   assign instr_count   = cnt_q;

endmodule

// File: tb/tb_instr_sequencer.sv
module tb_instr_sequencer;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic start = 1'b0;
   logic start2 = 1'b0;
   always #5 clk = ~clk;

   instr_sequencer_if #(.PC_W(8)) bus ();
   instr_sequencer_if #(.PC_W(2)) bus2 ();

   logic [15:0] ir, instr_count, ir2, instr_count2;
   logic        rf_we, busy, halted, illegal_op;
   logic        rf_we2, busy2, halted2, illegal_op2;

   instr_sequencer #(.PC_W(8)) dut (
      .clk(clk), .rst(rst), .start(start), .bus(bus),
      .ir(ir), .rf_we(rf_we), .busy(busy), .halted(halted),
      .illegal_op(illegal_op), .instr_count(instr_count)
   );

   // Small-PC instance: always acks immediately and always returns NOP
   assign bus2.imem_ack   = 1'b1;
   assign bus2.imem_rdata = 16'h0000;
   assign bus2.dmem_ack   = 1'b0;

   instr_sequencer #(.PC_W(2)) dut2 (
      .clk(clk), .rst(rst), .start(start2), .bus(bus2),
      .ir(ir2), .rf_we(rf_we2), .busy(busy2), .halted(halted2),
      .illegal_op(illegal_op2), .instr_count(instr_count2)
   );

   typedef struct packed {
      logic        imem_req;
      logic [7:0]  addr;
      logic        dmem_req;
      logic        dmem_we;
      logic        rf_we;
      logic        ill;
      logic        busy;
      logic        halted;
      logic [15:0] ir;
      logic [15:0] cnt;
   } out_t;

   typedef struct packed {
      logic        imem_ack;
      logic [15:0] rdata;
      logic        dmem_ack;
   } in_t;

   out_t exp_q[$];
   out_t obs_q[$];
   in_t  stim_q[$];

   // Architectural model state
   logic [7:0]  m_pc = 8'h00;
   logic [15:0] m_ir = 16'h0000;
   logic [15:0] m_cnt = 16'h0000;

   int n_vec = 0;
   int n_mis = 0;

   function automatic logic [15:0] sat_inc(input logic [15:0] c);
      return (c == 16'hFFFF) ? c : c + 16'd1;
   endfunction

   // Append one expected cycle plus the inputs to drive during it
   task automatic add_cyc(input logic ireq, input logic dreq, input logic dwe, input logic rfwe,
                          input logic ill, input logic hlt, input logic iack, input logic dack,
                          input logic [15:0] rd);
      out_t o;
      in_t  s;
      o.imem_req = ireq;
      o.addr     = m_pc;
      o.dmem_req = dreq;
      o.dmem_we  = dwe;
      o.rf_we    = rfwe;
      o.ill      = ill;
      o.busy     = !hlt;
      o.halted   = hlt;
      o.ir       = m_ir;
      o.cnt      = m_cnt;
      s.imem_ack = iack;
      s.rdata    = rd;
      s.dmem_ack = dack;
      exp_q.push_back(o);
      stim_q.push_back(s);
   endtask

   // One instruction: fd cycles of fetch wait, md cycles of data wait
   task automatic add_instr(input logic [15:0] instr, input int fd, input int md);
      logic [3:0] op;
      logic       st;
      op = instr[15:12];
      for (int k = 0; k < fd; k++)
         add_cyc(1, 0, 0, 0, 0, 0, 1'b0, 1'($urandom), 16'($urandom));
      add_cyc(1, 0, 0, 0, 0, 0, 1'b1, 1'($urandom), instr);
      m_ir = instr;
      m_pc = m_pc + 8'd1;
      add_cyc(0, 0, 0, 0, (op >= 4'd9 && op <= 4'd14), 0, 1'($urandom), 1'($urandom), 16'($urandom));
      if (op >= 4'd1 && op <= 4'd6) begin
         add_cyc(0, 0, 0, 0, 0, 0, 1'($urandom), 1'($urandom), 16'($urandom));
         add_cyc(0, 0, 0, 1, 0, 0, 1'($urandom), 1'($urandom), 16'($urandom));
         m_cnt = sat_inc(m_cnt);
      end else if (op == 4'd7 || op == 4'd8) begin
         st = (op == 4'd8);
         for (int k = 0; k < md; k++)
            add_cyc(0, 1, st, 0, 0, 0, 1'($urandom), 1'b0, 16'($urandom));
         add_cyc(0, 1, st, 0, 0, 0, 1'($urandom), 1'b1, 16'($urandom));
         if (!st) add_cyc(0, 0, 0, 1, 0, 0, 1'($urandom), 1'($urandom), 16'($urandom));
         m_cnt = sat_inc(m_cnt);
      end else begin
         m_cnt = sat_inc(m_cnt);
      end
   endtask

   task automatic add_halt_tail(input int n);
      for (int k = 0; k < n; k++)
         add_cyc(0, 0, 0, 0, 0, 1, 1'($urandom), 1'($urandom), 16'($urandom));
   endtask

   task automatic new_program;
      exp_q.delete();
      stim_q.delete();
      m_pc  = 8'h00;
      m_cnt = 16'h0000;
   endtask

   function automatic out_t sample();
      out_t o;
      o.imem_req = bus.imem_req;
      o.addr     = bus.imem_addr;
      o.dmem_req = bus.dmem_req;
      o.dmem_we  = bus.dmem_we & bus.dmem_req;
      o.rf_we    = rf_we;
      o.ill      = illegal_op;
      o.busy     = busy;
      o.halted   = halted;
      o.ir       = ir;
      o.cnt      = instr_count;
      return o;
   endfunction

   // Pulses start, then drives the stimulus queue one cycle per entry, recording outputs.
   // Entered and left at 1 time unit after a rising edge.
   task automatic play;
      obs_q.delete();
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      foreach (stim_q[i]) begin
         obs_q.push_back(sample());
         bus.imem_ack   = stim_q[i].imem_ack;
         bus.imem_rdata = stim_q[i].rdata;
         bus.dmem_ack   = stim_q[i].dmem_ack;
         @(posedge clk); #1;
      end
      bus.imem_ack = 1'b0;
      bus.dmem_ack = 1'b0;
   endtask

   task automatic test_reset;
      rst = 1'b1;
      bus.imem_ack = 1'b1; bus.dmem_ack = 1'b1; bus.imem_rdata = 16'hFFFF;
      start = 1'b1; start2 = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      n_vec++; if (busy !== 1'b0 || halted !== 1'b0) begin n_mis++; $display("FAIL reset_status busy=%b halted=%b want 0 0", busy, halted); end
      n_vec++; if (bus.imem_req !== 1'b0 || bus.dmem_req !== 1'b0 || bus.dmem_we !== 1'b0) begin n_mis++; $display("FAIL reset_req imem=%b dmem=%b we=%b want 0", bus.imem_req, bus.dmem_req, bus.dmem_we); end
      n_vec++; if (rf_we !== 1'b0 || illegal_op !== 1'b0) begin n_mis++; $display("FAIL reset_strobes rf_we=%b ill=%b want 0", rf_we, illegal_op); end
      n_vec++; if (ir !== 16'h0 || instr_count !== 16'h0 || bus.imem_addr !== 8'h0) begin n_mis++; $display("FAIL reset_regs ir=%h cnt=%h pc=%h want 0", ir, instr_count, bus.imem_addr); end
      n_vec++; if (busy2 !== 1'b0 || bus2.imem_addr !== 2'd0) begin n_mis++; $display("FAIL reset_dut2 busy=%b pc=%h want 0", busy2, bus2.imem_addr); end
      rst = 1'b0;
      start = 1'b0; start2 = 1'b0;
      bus.imem_ack = 1'b0; bus.dmem_ack = 1'b0;
      @(posedge clk); #1;
      n_vec++; if (busy !== 1'b0) begin n_mis++; $display("FAIL idle_after_reset busy=%b want 0", busy); end
   endtask

   task automatic test_alu;
      new_program();
      add_instr(16'h1A08, 0, 0);
      add_instr(16'hF000, 0, 0);
      add_halt_tail(3);
      play();
      foreach (exp_q[i]) begin
         n_vec++;
         if (obs_q[i] !== exp_q[i]) begin n_mis++; $display("FAIL alu cyc%0d got %h want %h", i, obs_q[i], exp_q[i]); end
      end
      n_vec++; if (obs_q[3].rf_we !== 1'b1 || obs_q[0].addr !== 8'd0 || obs_q[4].addr !== 8'd1) begin n_mis++; $display("FAIL alu_timing rf_we@4=%b addr0=%h addr1=%h want 1 00 01", obs_q[3].rf_we, obs_q[0].addr, obs_q[4].addr); end
      n_vec++; if (halted !== 1'b1 || instr_count !== 16'd2) begin n_mis++; $display("FAIL alu_end halted=%b cnt=%0d want 1 2", halted, instr_count); end
   endtask

   task automatic test_load;
      new_program();
      add_instr(16'h7000, 0, 3);
      add_instr(16'hF000, 1, 0);
      add_halt_tail(2);
      play();
      foreach (exp_q[i]) begin
         n_vec++;
         if (obs_q[i] !== exp_q[i]) begin n_mis++; $display("FAIL load cyc%0d got %h want %h", i, obs_q[i], exp_q[i]); end
      end
   endtask

   task automatic test_store;
      new_program();
      add_instr(16'h8000, 2, 2);
      add_instr(16'hF000, 0, 0);
      add_halt_tail(2);
      play();
      foreach (exp_q[i]) begin
         n_vec++;
         if (obs_q[i] !== exp_q[i]) begin n_mis++; $display("FAIL store cyc%0d got %h want %h", i, obs_q[i], exp_q[i]); end
      end
   endtask

   task automatic test_illegal;
      new_program();
      add_instr(16'hB123, 0, 0);
      add_instr(16'h0000, 1, 0);
      add_instr(16'hF000, 0, 0);
      add_halt_tail(2);
      play();
      foreach (exp_q[i]) begin
         n_vec++;
         if (obs_q[i] !== exp_q[i]) begin n_mis++; $display("FAIL illegal cyc%0d got %h want %h", i, obs_q[i], exp_q[i]); end
      end
   endtask

   task automatic test_random;
      int errs;
      errs = 0;
      new_program();
      for (int n = 0; n < 300; n++)
         add_instr({4'($urandom_range(0, 14)), 12'($urandom)}, $urandom_range(0, 3), $urandom_range(0, 3));
      add_instr(16'hF000, $urandom_range(0, 2), 0);
      add_halt_tail(2);
      play();
      foreach (exp_q[i]) begin
         n_vec++;
         if (obs_q[i] !== exp_q[i]) begin
            n_mis++;
            errs++;
            if (errs <= 10) $display("FAIL random cyc%0d got %h want %h", i, obs_q[i], exp_q[i]);
         end
      end
   endtask

   task automatic test_reset_mid;
      new_program();
      add_instr(16'h7000, 0, 8);
      while (exp_q.size() > 4) begin
         void'(exp_q.pop_back());
         void'(stim_q.pop_back());
      end
      play();
      foreach (exp_q[i]) begin
         n_vec++;
         if (obs_q[i] !== exp_q[i]) begin n_mis++; $display("FAIL mid_pre cyc%0d got %h want %h", i, obs_q[i], exp_q[i]); end
      end
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      n_vec++; if (busy !== 1'b0 || bus.dmem_req !== 1'b0 || instr_count !== 16'd0 || rf_we !== 1'b0) begin n_mis++; $display("FAIL mid_reset busy=%b dreq=%b cnt=%0d rf_we=%b want 0 0 0 0", busy, bus.dmem_req, instr_count, rf_we); end
      bus.dmem_ack = 1'b1;
      bus.imem_ack = 1'b1;
      bus.imem_rdata = 16'h1234;
      for (int k = 0; k < 3; k++) begin
         @(posedge clk); #1;
         n_vec++; if (busy !== 1'b0 || bus.dmem_req !== 1'b0 || rf_we !== 1'b0 || ir !== 16'h0) begin n_mis++; $display("FAIL spurious_ack%0d busy=%b dreq=%b rf_we=%b ir=%h want 0 0 0 0000", k, busy, bus.dmem_req, rf_we, ir); end
      end
      bus.dmem_ack = 1'b0;
      bus.imem_ack = 1'b0;
      new_program();
      m_ir = 16'h0000;
      add_instr(16'h0000, 0, 0);
      add_instr(16'hF000, 0, 0);
      add_halt_tail(1);
      play();
      foreach (exp_q[i]) begin
         n_vec++;
         if (obs_q[i] !== exp_q[i]) begin n_mis++; $display("FAIL mid_restart cyc%0d got %h want %h", i, obs_q[i], exp_q[i]); end
      end
   endtask

   task automatic test_wrap2;
      logic [1:0] got[$];
      logic [1:0] want[5];
      want[0] = 2'd0; want[1] = 2'd1; want[2] = 2'd2; want[3] = 2'd3; want[4] = 2'd0;
      start2 = 1'b1;
      @(posedge clk); #1;
      start2 = 1'b0;
      for (int c = 0; c < 20 && got.size() < 5; c++) begin
         if (bus2.imem_req === 1'b1) got.push_back(bus2.imem_addr);
         @(posedge clk); #1;
      end
      n_vec++;
      if (got.size() != 5) begin
         n_mis++;
         $display("FAIL wrap2_fetches got %0d fetches want 5", got.size());
      end else begin
         for (int k = 0; k < 5; k++) begin
            n_vec++;
            if (got[k] !== want[k]) begin n_mis++; $display("FAIL wrap2_addr%0d got %0d want %0d", k, got[k], want[k]); end
         end
      end
   endtask

   initial begin
      bus.imem_ack   = 1'b0;
      bus.imem_rdata = 16'h0000;
      bus.dmem_ack   = 1'b0;
      test_reset();
      test_alu();
      test_load();
      test_store();
      test_illegal();
      test_random();
      test_reset_mid();
      test_wrap2();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
      $finish;
   end

endmodule

// File: doc/instr_sequencer.md
INSTR_SEQUENCER -- requirements
Module: instr_sequencer

Interface
REQ-001 SHALL have parameter PC_W, default 8, meaning program-counter and instruction-address width.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port start  input  1  begin execution at address 0; honored only in IDLE or HALTED.
REQ-005 SHALL have port imem_req  output  1  instruction fetch request.
REQ-006 SHALL have port imem_addr  output  PC_W  fetch address, equal to pc.
REQ-007 SHALL have port imem_ack  input  1  fetch complete; imem_rdata valid this cycle.
REQ-008 SHALL have port imem_rdata  input  16  fetched instruction word.
REQ-009 SHALL have port ir  output  16  latched instruction driving the datapath (opcode ir[15:12], regs ir[11:9], ir[8:6], ir[5:3]).
REQ-010 SHALL have port rf_we  output  1  register-file write strobe.
REQ-011 SHALL have port dmem_req  output  1  data-memory request.
REQ-012 SHALL have port dmem_we  output  1  1 = store, 0 = load; meaningful only while dmem_req=1.
REQ-013 SHALL have port dmem_ack  input  1  data access complete.
REQ-014 SHALL have port busy  output  1  high in every state except IDLE and HALTED.
REQ-015 SHALL have port halted  output  1  high only in HALTED.
REQ-016 SHALL have port illegal_op  output  1  one-cycle pulse on decode of an unassigned opcode.
REQ-017 SHALL have port instr_count  output  16  count of retired instructions.

Function
REQ-018 SHALL implement states IDLE, FETCH, DECODE, EXEC, MEM, WB, HALTED; all outputs decode from registered state and registers, so there are no combinational input-to-output paths.
REQ-019 SHALL be in IDLE after reset; start=1 in IDLE or HALTED: pc<=0, instr_count<=0, next state FETCH; start is ignored in all other states.
REQ-020 SHALL, in FETCH, hold imem_req=1 and imem_addr=pc stable until imem_ack=1; on the ack cycle: ir<=imem_rdata, pc<=pc+1 modulo 2^PC_W (so pc wraps from all-ones to 0), next state DECODE.
REQ-021 SHALL, in DECODE (exactly one cycle), dispatch on ir[15:12]: 0001-0110 (ALU ops) -> EXEC; 0111 (LOAD) -> MEM with dmem_we=0; 1000 (STORE) -> MEM with dmem_we=1; 0000 (NOP) -> retire, FETCH; 1111 (HALT) -> retire, HALTED; 1001-1110 -> illegal_op=1 for one cycle, retire as NOP, FETCH.
REQ-022 SHALL, in EXEC, hold for exactly one cycle (datapath settle) and then go to WB.
REQ-023 SHALL, in MEM, hold dmem_req=1 and a stable dmem_we until dmem_ack=1; on ack, LOAD -> WB and STORE -> retire, FETCH.
REQ-024 SHALL, in WB, assert rf_we=1 for exactly one cycle, retire, and go to FETCH; rf_we SHALL be 0 in every other state.
REQ-025 SHALL increment instr_count by 1 at each retire, saturating at 16'hFFFF.
REQ-026 SHALL hold ir constant from DECODE through the end of the instruction.
REQ-027 SHALL ignore imem_ack outside FETCH and dmem_ack outside MEM; pc, ir and state are unaffected.
REQ-028 SHALL have these latencies with same-cycle acks: ALU 4 cycles (FETCH, DECODE, EXEC, WB); LOAD 4; STORE 3; NOP/illegal/HALT 2.
REQ-029 SHALL keep imem_req=0 and dmem_req=0 in IDLE, DECODE, EXEC, WB, HALTED.

Reset
REQ-030 SHALL, with rst=1 on a rising edge, set state=IDLE, pc=0, ir=0, instr_count=0, and drive imem_req, dmem_req, dmem_we, rf_we, busy, halted, illegal_op all 0; rst has priority over start and acks.
REQ-031 SHALL abandon any in-flight fetch or data access on reset mid-operation: request deasserted the next cycle and no rf_we issued.

Verification
REQ-032 SHALL pass: start, program {0x1A08 ADD, 0xF000 HALT}, acks same-cycle -> rf_we pulses once in cycle 4 after start; halted=1; instr_count=2; imem_addr seen 0 then 1.
REQ-033 SHALL pass: LOAD 0x7000 with dmem_ack delayed 3 cycles -> dmem_req=1, dmem_we=0 for 4 cycles; then rf_we one cycle; ir unchanged throughout.
REQ-034 SHALL pass: STORE 0x8000 -> dmem_req=1, dmem_we=1 until ack; rf_we never asserted; next FETCH immediately after ack.
REQ-035 SHALL pass: opcode 0xB -> illegal_op one-cycle pulse; instr_count +1; no rf_we or dmem_req; fetch continues at pc+1.
REQ-036 SHALL pass: PC_W=2, four NOPs then a fifth fetch -> imem_addr sequence 0,1,2,3,0.
REQ-037 SHALL pass: rst asserted while in MEM awaiting ack -> next cycle IDLE, dmem_req=0, instr_count=0; a spurious dmem_ack afterwards has no effect; start restarts at address 0.
